// File: rtl/safe_pkg.sv
// Shared types and encodings for the safe front-end controller.
package safe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PENALTY = 3'd4,
    ST_RELOCK  = 3'd5
  } ctrl_state_t;

  localparam int PIN_LEN = 4;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_KP   = 2'b01;
  localparam logic [1:0] REQ_RC   = 2'b10;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/safe_access_ctrl_if.sv
// Digit-entry handshakes (keypad, remote console) and the link to the safe core.
// valid/ready: a digit moves on a rising edge where valid & ready are both high; the source holds
// valid and its digit stable until then, and ready never depends on valid.
interface safe_access_ctrl_if;
  logic [3:0] kp_digit;
  logic       kp_valid;
  logic       kp_ready;
  logic [3:0] rc_digit;
  logic       rc_valid;
  logic       rc_ready;
  logic [3:0] safe_din;
  logic       safe_din_valid;
  logic       safe_reset;
  logic       safe_unlocked;

  modport slave (
    input  kp_digit, kp_valid, rc_digit, rc_valid, safe_unlocked,
    output kp_ready, rc_ready, safe_din, safe_din_valid, safe_reset
  );

  modport master (
    output kp_digit, kp_valid, rc_digit, rc_valid, safe_unlocked,
    input  kp_ready, rc_ready, safe_din, safe_din_valid, safe_reset
  );
endinterface

// File: rtl/safe_rr_arb2.sv
// Two-way round-robin arbiter: bit0 = keypad, bit1 = remote; pointer moves past the winner on take.
module safe_rr_arb2
  import safe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  logic ptr_rc;

  always_comb begin
    grant = REQ_NONE;
    if (req == 2'b11)  grant = ptr_rc ? REQ_RC : REQ_KP;
    else if (req[0])   grant = REQ_KP;
    else if (req[1])   grant = REQ_RC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_rc <= 1'b0;
    end else if (take && (grant != REQ_NONE)) begin
      ptr_rc <= (grant == REQ_KP);
    end
  end

endmodule

// File: rtl/safe_access_ctrl.sv
// Front-end for the 4-digit PIN safe: arbitrates digit sources, forms attempts,
// applies growing penalties after failures and relocks the safe after a hold time.
module safe_access_ctrl
  import safe_pkg::*;
#(
  parameter int DIGIT_TIMEOUT = 64,
  parameter int BASE_PENALTY  = 16,
  parameter int MAX_SHIFT     = 4,
  parameter int RELOCK_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  safe_access_ctrl_if.slave   bus,
  input  logic                relock,
  output logic [1:0]          owner,
  output logic                is_open,
  output logic                in_penalty,
  output logic [3:0]          fail_count,
  output ctrl_state_t         dbg_state
);

  ctrl_state_t state, next_state;
  logic [1:0]  owner_q;
  logic [2:0]  dig_cnt;
  logic [15:0] idle_cnt;
  logic [15:0] hold_cnt;
  logic [31:0] pen_cnt;
  logic [3:0]  fail_q;
  logic [3:0]  din_q;
  logic        din_valid_q;
  logic        rst_pulse_q;

  logic [1:0]  grant;
  logic        take;
  logic        kp_rdy, rc_rdy, hs;
  logic        enter_pen;
  logic [3:0]  fail_new, shift_amt;
  logic [31:0] pen_load;

  safe_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.rc_valid, bus.kp_valid}),
    .take  (take),
    .grant (grant)
  );

  always_comb begin
    next_state = state;
    take       = 1'b0;
    kp_rdy     = (state == ST_COLLECT) && (owner_q == REQ_KP) && (dig_cnt < 3'(PIN_LEN));
    rc_rdy     = (state == ST_COLLECT) && (owner_q == REQ_RC) && (dig_cnt < 3'(PIN_LEN));
    hs         = (bus.kp_valid && kp_rdy) || (bus.rc_valid && rc_rdy);
    case (state)
      ST_IDLE: begin
        if (grant != REQ_NONE) begin
          take       = 1'b1;
          next_state = ST_COLLECT;
        end
      end
      // The cycle with dig_cnt == PIN_LEN is the 4th digit's strobe cycle.
      ST_COLLECT: begin
        if (dig_cnt == 3'(PIN_LEN))                              next_state = ST_CHECK;
        else if (!hs && (idle_cnt == 16'(DIGIT_TIMEOUT - 1)))   next_state = ST_PENALTY;
      end
      ST_CHECK:   next_state = bus.safe_unlocked ? ST_OPEN : ST_PENALTY;
      ST_OPEN: begin
        if (relock || (hold_cnt == 16'(RELOCK_CYCLES - 1))) next_state = ST_RELOCK;
      end
      // Leave so that IDLE is the cycle in which the down-counter reads 0.
      ST_PENALTY: begin
        if (pen_cnt <= 32'd1) next_state = ST_IDLE;
      end
      ST_RELOCK:  next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    enter_pen = (next_state == ST_PENALTY) && (state != ST_PENALTY);
    fail_new  = sat_inc4(fail_q);
    shift_amt = ((fail_new - 4'd1) > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : (fail_new - 4'd1);
    pen_load  = 32'(BASE_PENALTY) << shift_amt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner_q     <= REQ_NONE;
      dig_cnt     <= '0;
      idle_cnt    <= '0;
      hold_cnt    <= '0;
      pen_cnt     <= '0;
      fail_q      <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      rst_pulse_q <= 1'b0;
    end else begin
      state       <= next_state;
      din_valid_q <= hs;
      if (hs) din_q <= (owner_q == REQ_KP) ? bus.kp_digit : bus.rc_digit;
      rst_pulse_q <= enter_pen || (next_state == ST_RELOCK);

      if (take)                          owner_q <= grant;
      else if (next_state == ST_IDLE)    owner_q <= REQ_NONE;

      if (state != ST_COLLECT) begin
        dig_cnt  <= '0;
        idle_cnt <= '0;
      end else if (hs) begin
        dig_cnt  <= dig_cnt + 3'd1;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end

      hold_cnt <= (state == ST_OPEN) ? hold_cnt + 16'd1 : 16'd0;

      if (enter_pen) begin
        fail_q  <= fail_new;
        pen_cnt <= pen_load;
      end else if ((state == ST_PENALTY) && (pen_cnt != 32'd0)) begin
        pen_cnt <= pen_cnt - 32'd1;
      end
      if ((state == ST_CHECK) && bus.safe_unlocked) fail_q <= '0;
    end
  end

  assign bus.kp_ready       = kp_rdy;
  assign bus.rc_ready       = rc_rdy;
  assign bus.safe_din       = din_q;
  assign bus.safe_din_valid = din_valid_q;
  assign bus.safe_reset     = reset | rst_pulse_q;

  assign owner      = owner_q;
  assign is_open    = (state == ST_OPEN);
  assign in_penalty = (state == ST_PENALTY);
  assign fail_count = fail_q;
  assign dbg_state  = state;

endmodule
